// File: rtl/pin_input_conditioner_if.sv
// Pin-level signal bundle between the pad ring and the core's pin_in port.
// Purely level-based, no valid/ready: every field is meaningful on every clk_cog cycle.
interface pin_input_conditioner_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] pin_raw;
    logic [WIDTH-1:0] pin_out;
    logic [WIDTH-1:0] pin_dir;
    logic             glitch_clr;
    logic [WIDTH-1:0] pin_in;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [15:0]      glitch_count;

    modport master (
        output pin_raw, pin_out, pin_dir, glitch_clr,
        input  pin_in, rise, fall, glitch_count
    );

    modport slave (
        input  pin_raw, pin_out, pin_dir, glitch_clr,
        output pin_in, rise, fall, glitch_count
    );
endinterface

// File: rtl/pin_input_conditioner.sv
// Synchronizes raw pad levels into clk_cog, optionally glitch-filters them, loops back
// driven pins, and produces edge strobes plus a saturating rejected-glitch counter.
module pin_input_conditioner #(
    parameter int               WIDTH       = 32,
    parameter int               SYNC_STAGES = 2,
    parameter int               FILTER_LEN  = 3,
    parameter logic [WIDTH-1:0] FILTER_MASK = '0
) (
    input logic                     clk_cog,
    input logic                     nres,
    pin_input_conditioner_if.slave  bus
);
    localparam int CW = $clog2(FILTER_LEN + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_LEN - 1);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
    logic [WIDTH-1:0]                  s;
    logic [WIDTH-1:0]                  filt_q;
    logic [WIDTH-1:0]                  filt_next;
    logic [WIDTH-1:0][CW-1:0]          cnt_q;
    logic [WIDTH-1:0][CW-1:0]          cnt_next;
    logic [WIDTH-1:0]                  reject;
    logic [WIDTH-1:0]                  rise_q;
    logic [WIDTH-1:0]                  fall_q;
    logic [15:0]                       glitch_cnt_q;

    assign s = sync_q[SYNC_STAGES-1];

    // A filtered pin only moves after FILTER_LEN consecutive disagreeing samples;
    // a disagreement run that ends early is a rejected glitch.
    always_comb begin
        filt_next = filt_q;
        cnt_next  = cnt_q;
        reject    = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (!FILTER_MASK[i]) begin
                filt_next[i] = s[i];
            end else if (s[i] != filt_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    filt_next[i] = s[i];
                    cnt_next[i]  = '0;
                end else begin
                    cnt_next[i] = cnt_q[i] + CW'(1);
                end
            end else if (cnt_q[i] != '0) begin
                reject[i]   = 1'b1;
                cnt_next[i] = '0;
            end
        end
    end

    always_ff @(posedge clk_cog) begin
        if (!nres) begin
            sync_q <= '0;
            filt_q <= '0;
            cnt_q  <= '0;
            rise_q <= '0;
            fall_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], bus.pin_raw};
            filt_q <= filt_next;
            cnt_q  <= cnt_next;
            rise_q <= ~filt_q & filt_next & ~bus.pin_dir;
            fall_q <= filt_q & ~filt_next & ~bus.pin_dir;
        end
    end

    // One count per cycle regardless of how many pins reject; clear wins.
    always_ff @(posedge clk_cog) begin
        if (!nres || bus.glitch_clr) begin
            glitch_cnt_q <= '0;
        end else if (|reject && glitch_cnt_q != 16'hFFFF) begin
            glitch_cnt_q <= glitch_cnt_q + 16'd1;
        end
    end

    assign bus.pin_in       = (bus.pin_dir & bus.pin_out) | (~bus.pin_dir & filt_q);
    assign bus.rise         = rise_q;
    assign bus.fall         = fall_q;
    assign bus.glitch_count = glitch_cnt_q;
endmodule

// File: tb/tb_pin_input_conditioner.sv
// Directed bench for pin_input_conditioner: pins 0 and 1 filtered, all others unfiltered.
module tb_pin_input_conditioner;
    logic clk_cog;
    logic nres;
    int   tests;
    int   fails;

    pin_input_conditioner_if #(.WIDTH(32)) bus_if ();

    pin_input_conditioner #(
        .WIDTH      (32),
        .SYNC_STAGES(2),
        .FILTER_LEN (3),
        .FILTER_MASK(32'h0000_0003)
    ) dut (
        .clk_cog(clk_cog),
        .nres   (nres),
        .bus    (bus_if)
    );

    initial clk_cog = 1'b0;
    always #5 clk_cog = ~clk_cog;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge clk_cog);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Two-cycle high pulse on the given pins, then wait for the filter to settle.
    task automatic pulse2(input logic [31:0] pins);
        bus_if.pin_raw = pins;
        tick(2);
        bus_if.pin_raw = '0;
        tick(6);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        nres = 1'b0;
        bus_if.pin_raw    = 32'hFFFF_FFFF;
        bus_if.pin_out    = '0;
        bus_if.pin_dir    = '0;
        bus_if.glitch_clr = 1'b0;

        // Reset values
        tick(3);
        chk("rst_pin_in", bus_if.pin_in, 32'h0);
        chk("rst_rise", bus_if.rise, 32'h0);
        chk("rst_fall", bus_if.fall, 32'h0);
        chk("rst_gc", {16'h0, bus_if.glitch_count}, 32'h0);

        // Release: unfiltered pins at edge 3, filtered at edge 5
        nres = 1'b1;
        tick(2);
        chk("rel_e2_pin_in", bus_if.pin_in, 32'h0);
        tick(1);
        chk("rel_e3_pin_in", bus_if.pin_in, 32'hFFFF_FFFC);
        chk("rel_e3_rise", bus_if.rise, 32'hFFFF_FFFC);
        tick(1);
        chk("rel_e4_rise", bus_if.rise, 32'h0);
        chk("rel_e4_pin_in", bus_if.pin_in, 32'hFFFF_FFFC);
        tick(1);
        chk("rel_e5_pin_in", bus_if.pin_in, 32'hFFFF_FFFF);
        chk("rel_e5_rise", bus_if.rise, 32'h0000_0003);
        tick(1);
        chk("rel_e6_rise", bus_if.rise, 32'h0);

        // Falling edges back to all-zero
        bus_if.pin_raw = '0;
        tick(3);
        chk("fall_e3", bus_if.fall, 32'hFFFF_FFFC);
        tick(2);
        chk("fall_e5", bus_if.fall, 32'h0000_0003);
        chk("fall_e5_pin_in", bus_if.pin_in, 32'h0);
        tick(1);
        chk("fall_e6", bus_if.fall, 32'h0);

        // Filtered rise on pin 0: exactly 5 edges
        bus_if.pin_raw = 32'h1;
        tick(4);
        chk("frise_e4_pin_in", bus_if.pin_in, 32'h0);
        tick(1);
        chk("frise_e5_pin_in", bus_if.pin_in, 32'h1);
        chk("frise_e5_rise", bus_if.rise, 32'h1);
        tick(1);
        chk("frise_e6_rise", bus_if.rise, 32'h0);
        chk("frise_gc", {16'h0, bus_if.glitch_count}, 32'h0);
        bus_if.pin_raw = '0;
        tick(6);
        chk("frise_back_low", bus_if.pin_in, 32'h0);

        // Two-cycle glitch on pin 0 is rejected and counted
        bus_if.pin_raw = 32'h1;
        for (int k = 0; k < 8; k++) begin
            if (k == 2) bus_if.pin_raw = '0;
            tick(1);
            chk("glitch_pin_in", bus_if.pin_in, 32'h0);
            chk("glitch_rise", bus_if.rise, 32'h0);
        end
        chk("glitch_gc1", {16'h0, bus_if.glitch_count}, 32'h1);

        // Simultaneous glitches on pins 0 and 1 add only one
        pulse2(32'h3);
        chk("glitch2_gc", {16'h0, bus_if.glitch_count}, 32'h2);
        chk("glitch2_pin_in", bus_if.pin_in, 32'h0);

        // Loopback on pin 5
        bus_if.pin_dir = 32'h20;
        bus_if.pin_out = 32'h20;
        #1;
        chk("loop_hi_comb", bus_if.pin_in, 32'h20);
        for (int k = 0; k < 4; k++) begin
            tick(1);
            bus_if.pin_out = bus_if.pin_out ^ 32'h20;
            #1;
            chk("loop_follow", bus_if.pin_in, bus_if.pin_out & 32'h20);
            chk("loop_rise", bus_if.rise, 32'h0);
            chk("loop_fall", bus_if.fall, 32'h0);
        end
        bus_if.pin_out = 32'h20;
        #1;
        bus_if.pin_dir = '0;
        #1;
        chk("loop_release", bus_if.pin_in, 32'h0);
        tick(1);
        chk("loop_release_rise", bus_if.rise, 32'h0);
        bus_if.pin_out = '0;

        // Saturation from a preloaded value
        force dut.glitch_cnt_q = 16'hFFFE;
        tick(1);
        release dut.glitch_cnt_q;
        tick(1);
        chk("sat_preload", {16'h0, bus_if.glitch_count}, 32'h0000_FFFE);
        pulse2(32'h1);
        chk("sat_ffff", {16'h0, bus_if.glitch_count}, 32'h0000_FFFF);
        pulse2(32'h1);
        chk("sat_hold", {16'h0, bus_if.glitch_count}, 32'h0000_FFFF);

        // Clear alone, then clear coinciding with a rejection edge
        bus_if.glitch_clr = 1'b1;
        tick(1);
        bus_if.glitch_clr = 1'b0;
        chk("clr_alone", {16'h0, bus_if.glitch_count}, 32'h0);
        bus_if.pin_raw = 32'h1;
        tick(2);
        bus_if.pin_raw = '0;
        tick(2);
        bus_if.glitch_clr = 1'b1;
        tick(1);
        bus_if.glitch_clr = 1'b0;
        chk("clr_priority", {16'h0, bus_if.glitch_count}, 32'h0);
        tick(3);
        chk("clr_after", {16'h0, bus_if.glitch_count}, 32'h0);

        // Reset in the middle of a filter count
        bus_if.pin_raw = 32'h1;
        tick(4);
        nres = 1'b0;
        tick(1);
        chk("midrst_pin_in", bus_if.pin_in, 32'h0);
        chk("midrst_gc", {16'h0, bus_if.glitch_count}, 32'h0);
        nres = 1'b1;
        tick(4);
        chk("midrst_e4_pin_in", bus_if.pin_in, 32'h0);
        tick(1);
        chk("midrst_e5_pin_in", bus_if.pin_in, 32'h1);
        chk("midrst_e5_rise", bus_if.rise, 32'h1);
        chk("midrst_gc_end", {16'h0, bus_if.glitch_count}, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
